// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_pkg
// Description : Shared constants, port index type and select decoder for
//               the 1-to-4 handshake demultiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

   localparam int NUM_PORTS = 4;
   localparam int SEL_W     = 2;

   typedef logic [SEL_W-1:0] port_idx_t;

   // One-hot decode of a destination port index.
   function automatic logic [NUM_PORTS-1:0] port_decode(input port_idx_t idx);
      logic [NUM_PORTS-1:0] onehot;
      onehot      = '0;
      onehot[idx] = 1'b1;
      return onehot;
   endfunction

endpackage
`default_nettype wire

// File: rtl/demux4_if.sv
`default_nettype none
// ============================================================================
// Module      : demux4_if
// Description : Producer stream plus four consumer channels of the demux.
//               The slave modport is the demultiplexer's view; the master
//               modport is the surrounding producer/consumer view.
// Revision    : 1.0 - initial release
// ============================================================================
interface demux4_if #(
   parameter int WIDTH = 8
);
   import demux_pkg::*;

   logic [WIDTH-1:0]     din;
   port_idx_t            select;
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     dout1;
   logic [WIDTH-1:0]     dout2;
   logic [WIDTH-1:0]     dout3;
   logic [WIDTH-1:0]     dout4;
   logic [NUM_PORTS-1:0] out_valid;
   logic [NUM_PORTS-1:0] out_ready;
   logic                 busy;

   modport slave (
      input  din, select, in_valid, out_ready,
      output in_ready, dout1, dout2, dout3, dout4, out_valid, busy
   );

   modport master (
      output din, select, in_valid, out_ready,
      input  in_ready, dout1, dout2, dout3, dout4, out_valid, busy
   );

endinterface
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// ============================================================================
// Module      : demux_slot
// Description : One-entry holding register for a single output channel.
//               A load always wins, so a same-cycle drain and fill replaces
//               the word without a bubble. A drain alone only clears valid;
//               the data register keeps its last value.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_slot #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] q
);

   logic             valid_d, valid_q;
   logic [WIDTH-1:0] data_d,  data_q;

   // Next-state: fill has priority over drain; hold otherwise.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = d;
      end else if (valid_q && ready) begin
         valid_d = 1'b0;
      end
   end

   // Slot registers, cleared immediately by the asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign q     = data_q;

endmodule
`default_nettype wire

// File: rtl/demux4.sv
`default_nettype none
// ============================================================================
// Module      : demux4
// Description : Registered 1-to-4 demultiplexer with valid/ready handshake.
//               Each output has its own one-entry slot, so a stalled
//               consumer only back-pressures words addressed to it.
// Revision    : 1.0 - initial release
// ============================================================================
module demux4
   import demux_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic     clk,
   input  logic     rst_n,
   demux4_if.slave  bus
);

   logic [NUM_PORTS-1:0] sel_dec;
   logic [NUM_PORTS-1:0] load;
   logic [NUM_PORTS-1:0] slot_valid;
   logic [WIDTH-1:0]     slot_q [NUM_PORTS];
   logic                 in_ready;

   // Target slot can take a word when empty or draining this cycle; load is
   // gated by in_valid so an idle select/din never reaches a slot.
   always_comb begin
      sel_dec  = port_decode(bus.select);
      in_ready = !slot_valid[bus.select] || bus.out_ready[bus.select];
      load     = {NUM_PORTS{bus.in_valid && in_ready}} & sel_dec;
   end

   generate
      for (genvar i = 0; i < NUM_PORTS; i++) begin : g_slot
         demux_slot #(
            .WIDTH (WIDTH)
         ) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[i]),
            .d     (bus.din),
            .ready (bus.out_ready[i]),
            .valid (slot_valid[i]),
            .q     (slot_q[i])
         );
      end
   endgenerate

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = slot_valid;
   assign bus.busy      = |slot_valid;
   assign bus.dout1     = slot_q[0];
   assign bus.dout2     = slot_q[1];
   assign bus.dout3     = slot_q[2];
   assign bus.dout4     = slot_q[3];

endmodule
`default_nettype wire

// File: tb/tb_demux4.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux4
// Description : Self-checking bench for demux4. Accepted words are queued
//               per destination port and checked against the port data when
//               the consumer takes them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux4;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   logic [7:0] sb0[$];
   logic [7:0] sb1[$];
   logic [7:0] sb2[$];
   logic [7:0] sb3[$];

   demux4_if #(.WIDTH(8)) bus ();

   demux4 #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] get_dout(input int i);
      case (i)
         0: return bus.dout1;
         1: return bus.dout2;
         2: return bus.dout3;
         default: return bus.dout4;
      endcase
   endfunction

   task automatic sb_push(input int p, input logic [7:0] d);
      case (p)
         0: sb0.push_back(d);
         1: sb1.push_back(d);
         2: sb2.push_back(d);
         default: sb3.push_back(d);
      endcase
   endtask

   task automatic sb_clear();
      sb0.delete(); sb1.delete(); sb2.delete(); sb3.delete();
   endtask

   // Output monitor: a word is delivered at the next edge when valid and
   // ready are both high; compare it against the oldest expected word.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.out_valid[i] === 1'b1 && bus.out_ready[i] === 1'b1) begin
               logic [7:0] exp_d;
               logic       empty;
               empty = 1'b0;
               exp_d = 8'h00;
               case (i)
                  0: if (sb0.size() == 0) empty = 1'b1; else exp_d = sb0.pop_front();
                  1: if (sb1.size() == 0) empty = 1'b1; else exp_d = sb1.pop_front();
                  2: if (sb2.size() == 0) empty = 1'b1; else exp_d = sb2.pop_front();
                  default: if (sb3.size() == 0) empty = 1'b1; else exp_d = sb3.pop_front();
               endcase
               n_cmp++;
               if (empty) begin
                  n_err++;
                  $display("FAIL sb_unexpected port %0d: delivered %h, expected no word", i, get_dout(i));
               end else if (get_dout(i) !== exp_d) begin
                  n_err++;
                  $display("FAIL sb_data port %0d: got %h, expected %h", i, get_dout(i), exp_d);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a word for one cycle; check in_ready and queue it if accepted.
   task automatic send(input int p, input logic [7:0] d, input logic exp_rdy);
      bus.in_valid = 1'b1;
      bus.select   = p[1:0];
      bus.din      = d;
      #1;
      n_cmp++;
      if (bus.in_ready !== exp_rdy) begin
         n_err++;
         $display("FAIL in_ready port %0d: got %b, expected %b", p, bus.in_ready, exp_rdy);
      end
      if (exp_rdy) sb_push(p, d);
      tick();
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
      bus.select   = 2'd0;
      bus.din      = 8'h00;
   endtask

   task automatic chk_valid(input string name, input logic [3:0] exp_v);
      n_cmp++;
      if (bus.out_valid !== exp_v) begin
         n_err++;
         $display("FAIL %s out_valid: got %b, expected %b", name, bus.out_valid, exp_v);
      end
   endtask

   task automatic chk_dout(input string name, input int p, input logic [7:0] exp_d);
      n_cmp++;
      if (get_dout(p) !== exp_d) begin
         n_err++;
         $display("FAIL %s dout%0d: got %h, expected %h", name, p + 1, get_dout(p), exp_d);
      end
   endtask

   task automatic chk_busy(input string name, input logic exp_b);
      n_cmp++;
      if (bus.busy !== exp_b) begin
         n_err++;
         $display("FAIL %s busy: got %b, expected %b", name, bus.busy, exp_b);
      end
   endtask

   task automatic chk_reset_state(input string name);
      chk_valid(name, 4'b0000);
      for (int i = 0; i < 4; i++) chk_dout(name, i, 8'h00);
      chk_busy(name, 1'b0);
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL %s in_ready: got %b, expected 1", name, bus.in_ready);
      end
   endtask

   task automatic test_reset();
      rst_n         = 1'b0;
      bus.out_ready = 4'b0000;
      idle();
      repeat (2) @(posedge clk);
      #1;
      chk_reset_state("reset");
      rst_n = 1'b1;
      tick();
      chk_reset_state("reset_release");
   endtask

   task automatic test_stream();
      bus.out_ready = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         send(k, 8'(k + 1), 1'b1);
         chk_valid("stream", 4'(1 << k));
         chk_dout("stream", k, 8'(k + 1));
      end
      idle();
      tick();
      chk_valid("stream_drained", 4'b0000);
   endtask

   task automatic test_stall();
      bus.out_ready = 4'b0000;
      send(2, 8'hA5, 1'b1);
      chk_valid("stall_fill", 4'b0100);
      chk_dout("stall_fill", 2, 8'hA5);
      send(2, 8'h5A, 1'b0);
      chk_dout("stall_hold", 2, 8'hA5);
      chk_valid("stall_hold", 4'b0100);
      send(0, 8'h77, 1'b1);
      chk_valid("stall_other", 4'b0101);
      idle();
      bus.out_ready = 4'b1111;
      tick();
      chk_valid("stall_drained", 4'b0000);
   endtask

   task automatic test_fill_drain();
      bus.out_ready = 4'b0000;
      send(1, 8'h99, 1'b1);
      bus.out_ready = 4'b0010;
      send(1, 8'h3C, 1'b1);
      chk_valid("same_cycle", 4'b0010);
      chk_dout("same_cycle", 1, 8'h3C);
      idle();
      tick();
      chk_valid("same_cycle_drained", 4'b0000);
      chk_dout("keep_data", 1, 8'h3C);
   endtask

   task automatic test_partial_drain();
      bus.out_ready = 4'b0000;
      send(0, 8'h11, 1'b1);
      send(3, 8'h44, 1'b1);
      idle();
      bus.out_ready = 4'b1000;
      tick();
      chk_valid("partial", 4'b0001);
      chk_dout("partial", 3, 8'h44);
      chk_dout("partial", 0, 8'h11);
      chk_busy("partial", 1'b1);
      bus.out_ready = 4'b1111;
      tick();
      chk_valid("partial_drained", 4'b0000);
      chk_busy("partial_drained", 1'b0);
   endtask

   task automatic test_async_reset();
      bus.out_ready = 4'b0000;
      send(0, 8'hC1, 1'b1);
      send(1, 8'hC2, 1'b1);
      send(2, 8'hC3, 1'b1);
      send(3, 8'hC4, 1'b1);
      idle();
      chk_valid("all_full", 4'b1111);
      send(1, 8'hEE, 1'b0);
      idle();
      #2;
      rst_n = 1'b0;
      #1;
      sb_clear();
      chk_reset_state("async_reset");
      tick();
      rst_n = 1'b1;
      tick();
      chk_reset_state("async_release");
   endtask

   task automatic test_x_idle();
      bus.out_ready = 4'b0000;
      send(1, 8'h5E, 1'b1);
      bus.in_valid = 1'b0;
      bus.select   = 2'bxx;
      bus.din      = 8'hxx;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk_valid("x_idle", 4'b0010);
         chk_dout("x_idle", 1, 8'h5E);
         chk_dout("x_idle", 0, 8'h00);
         chk_dout("x_idle", 3, 8'h00);
         n_cmp++;
         if ($isunknown({bus.dout1, bus.dout2, bus.dout3, bus.dout4, bus.out_valid, bus.busy})) begin
            n_err++;
            $display("FAIL x_idle unknown: outputs %h %h %h %h %b, expected no X",
                     bus.dout1, bus.dout2, bus.dout3, bus.dout4, bus.out_valid);
         end
      end
      idle();
      bus.out_ready = 4'b1111;
      tick();
      chk_valid("x_idle_drained", 4'b0000);
   endtask

   initial begin
      n_cmp         = 0;
      n_err         = 0;
      rst_n         = 1'b0;
      bus.out_ready = 4'b0000;
      idle();
      test_reset();
      test_stream();
      test_stall();
      test_fill_drain();
      test_partial_drain();
      test_async_reset();
      test_x_idle();
      repeat (2) tick();
      n_cmp++;
      if (sb0.size() + sb1.size() + sb2.size() + sb3.size() != 0) begin
         n_err++;
         $display("FAIL sb_leftover: %0d words undelivered, expected 0",
                  sb0.size() + sb1.size() + sb2.size() + sb3.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
